// File: rtl/rr_mux_pipe.sv
// N-channel valid/ready mux with fixed or round-robin select.
// Single registered output word; full 1 word/cycle throughput.
module rr_mux_pipe #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  output logic [SEL_W-1:0]          out_chan,
  input  logic                      out_ready
);

  logic [WIDTH-1:0]    data_q, data_d;
  logic [SEL_W-1:0]    chan_q, chan_d;
  logic [SEL_W-1:0]    last_q, last_d;
  logic                valid_q, valid_d;
  logic [CHANNELS-1:0] grant;
  logic [SEL_W-1:0]    gnt_idx;
  logic [SEL_W-1:0]    cand;
  logic                found;
  logic                load;
  logic                xfer;

  // Search starts one past the last winner so it is visited last.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    cand    = '0;
    found   = 1'b0;
    if (mode) begin
      for (int k = 1; k <= CHANNELS; k++) begin
        cand = SEL_W'((int'(last_q) + k) % CHANNELS);
        if (!found && in_valid[cand]) begin
          found   = 1'b1;
          gnt_idx = cand;
        end
      end
    end else if (int'(sel) < CHANNELS) begin
      found   = in_valid[sel];
      gnt_idx = sel;
    end
    if (found) grant[gnt_idx] = 1'b1;
  end

  assign load     = rst_n && (!valid_q || out_ready);
  assign xfer     = found && load;
  assign in_ready = grant & {CHANNELS{load}};

  always_comb begin
    data_d  = data_q;
    chan_d  = chan_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (xfer) begin
      data_d  = in_data[int'(gnt_idx)*WIDTH +: WIDTH];
      chan_d  = gnt_idx;
      valid_d = 1'b1;
      if (mode) last_d = gnt_idx;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      chan_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= SEL_W'(CHANNELS - 1);
    end else begin
      data_q  <= data_d;
      chan_q  <= chan_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign out_data  = data_q;
  assign out_chan  = chan_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_rr_mux_pipe.sv
// Randomized bench for rr_mux_pipe against a behavioural model.
// Directed scenarios first, then random traffic.
module tb_rr_mux_pipe;

  localparam int W  = 16;
  localparam int C  = 4;
  localparam int SW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           mode;
  logic [SW-1:0]  sel;
  logic [C*W-1:0] in_data;
  logic [C-1:0]   in_valid;
  logic [C-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic [SW-1:0]  out_chan;
  logic           out_ready;

  logic [W-1:0] chd [C];

  int checks   = 0;
  int failures = 0;

  // model state
  bit ev;
  int ed;
  int ec;
  int elast;

  rr_mux_pipe #(.WIDTH(W), .CHANNELS(C)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_chan  (out_chan),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  always_comb begin
    in_data = '0;
    for (int i = 0; i < C; i++) in_data[i*W +: W] = chd[i];
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    ev    = 1'b0;
    ed    = 0;
    ec    = 0;
    elast = C - 1;
  endfunction

  function automatic int exp_grant();
    if (mode) begin
      for (int k = 1; k <= C; k++) begin
        int i;
        i = (elast + k) % C;
        if (in_valid[i]) return i;
      end
    end else begin
      if (int'(sel) < C && in_valid[sel]) return int'(sel);
    end
    return -1;
  endfunction

  // Call between posedge and negedge with inputs already set.
  task automatic tick();
    int g;
    bit ld;
    logic [C-1:0] er;
    @(negedge clk);
    g  = exp_grant();
    ld = !ev || out_ready;
    er = '0;
    if (g >= 0 && ld) er = C'(1) << g;
    chk("in_ready", 32'(in_ready), 32'(er));
    chk("out_valid", 32'(out_valid), 32'(ev));
    chk("out_data", 32'(out_data), ed);
    chk("out_chan", 32'(out_chan), ec);
    @(posedge clk);
    if (er != '0) begin
      ev = 1'b1;
      ed = int'(chd[g]);
      ec = g;
      if (mode) elast = g;
    end else if (out_ready) begin
      ev = 1'b0;
    end
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    mode      = 1'b1;
    sel       = '0;
    in_valid  = '1;
    out_ready = 1'b1;
    for (int i = 0; i < C; i++) chd[i] = W'($urandom);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_ready", 32'(in_ready), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // round-robin, all requesting
    for (int k = 0; k < 9; k++) begin
      for (int i = 0; i < C; i++) chd[i] = W'($urandom);
      tick();
      chk("rr_valid", 32'(out_valid), 1);
      chk("rr_seq", 32'(out_chan), k % C);
    end

    // fixed select
    mode   = 1'b0;
    sel    = 2'd2;
    chd[2] = 16'hBEEF;
    tick();
    chk("fix_data", 32'(out_data), 32'h BEEF);
    chk("fix_chan", 32'(out_chan), 2);

    // backpressure
    mode   = 1'b1;
    chd[1] = 16'h1234;
    tick();
    chk("bp_load", 32'(out_data), 32'h1234);
    out_ready = 1'b0;
    chd[2]    = 16'h5678;
    repeat (3) tick();
    chk("bp_hold_d", 32'(out_data), 32'h1234);
    chk("bp_hold_c", 32'(out_chan), 1);
    out_ready = 1'b1;
    tick();
    chk("bp_next_d", 32'(out_data), 32'h5678);
    chk("bp_next_c", 32'(out_chan), 2);

    // sparse requests
    in_valid = 4'b0001;
    tick();
    in_valid = 4'b1001;
    tick(); chk("sp0", 32'(out_chan), 3);
    tick(); chk("sp1", 32'(out_chan), 0);
    tick(); chk("sp2", 32'(out_chan), 3);
    in_valid = 4'b0001;
    tick(); chk("sp3", 32'(out_chan), 0);
    tick(); chk("sp4", 32'(out_chan), 0);

    // async reset in the middle of a stall
    in_valid  = '1;
    out_ready = 1'b0;
    tick();
    chk("stall_v", 32'(out_valid), 1);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", 32'(out_valid), 0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("post_rst", 32'(out_chan), 0);

    // random traffic
    repeat (3000) begin
      mode      = 1'($urandom);
      sel       = SW'($urandom);
      in_valid  = C'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < C; i++) chd[i] = W'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_mux_pipe.md
Name: rr_mux_pipe

Overview:
- Parametrised N-channel, WIDTH-bit multiplexer with per-channel valid/ready handshake and a one-entry registered output stage.
- Selects between channels in one of two modes: fixed (external select, same as the combinational mux tree) or round-robin arbitration across all requesting channels.
- Sits between multiple 16-bit ALU result producers and a single downstream consumer, which may stall.

Parameters:
- WIDTH, 16, data width of each channel and of the output.
- CHANNELS, 4, number of input channels; legal range 2..16.
- SEL_W, $clog2(CHANNELS), width of the select and channel-index fields. Derived; must not be overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SEL_W  channel index used in fixed mode; ignored in round-robin mode.
- in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  CHANNELS  per-channel request.
- in_ready  output  CHANNELS  per-channel accept, combinational.
- out_data  output  WIDTH  registered output data.
- out_valid  output  1  output register holds a word.
- out_chan  output  SEL_W  index of the channel that produced out_data.
- out_ready  input  1  downstream accept.

Behaviour:
- Reset, asynchronous on rst_n low:
  - out_valid=0, out_data=0, out_chan=0.
  - Round-robin pointer last=CHANNELS-1, so channel 0 has first priority.
  - Reset mid-transfer discards any held word; nothing is replayed after reset.
- Load enable: load = !out_valid || out_ready. The output register accepts a new word whenever it is empty or is being drained in the same cycle, giving full throughput of 1 word/cycle.
- Grant, combinational, one-hot or zero:
  - Fixed mode: grant[sel] = in_valid[sel]. All other grants are 0.
  - Fixed mode, sel >= CHANNELS (non-power-of-2 CHANNELS): grant=0 and nothing is accepted.
  - Round-robin mode: grant goes to the first i with in_valid[i]=1, searching last+1, last+2, ... with wrap modulo CHANNELS. Channel last is searched last.
- Handshake:
  - in_ready[i] = grant[i] && load. At most one in_ready is high per cycle.
  - Transfer on channel i occurs when in_valid[i] && in_ready[i].
  - in_ready may depend on in_valid; producers must not make in_valid depend on in_ready.
  - in_ready is 0 for every non-granted channel even if that channel is valid.
- Output register update, on posedge clk:
  - Transfer on channel i: out_data <= channel i data; out_chan <= i; out_valid <= 1.
  - No transfer and out_ready=1: out_valid <= 0. out_data and out_chan keep their old values.
  - out_valid=1 and out_ready=0: out_data, out_chan and out_valid hold stable, with no glitch or change until accepted.
- Latency: exactly 1 cycle from an input transfer to out_valid=1 with that word.
- Pointer:
  - last <= i only on a transfer in round-robin mode.
  - The pointer is unchanged in fixed mode, during stalls, and in idle cycles.
- Mode/sel changes:
  - Take effect in the same cycle's grant.
  - Never alter a word already held in the output register.
  - Switching fixed -> round-robin resumes from the retained pointer.
- Fairness: under continuous requests from k channels in round-robin mode, each requesting channel is served once every k transfers. Starvation is impossible.
- Simultaneous drain and load: out_ready=1 with a new transfer in the same cycle gives out_valid staying 1 and the new word replacing the old one. No bubble is inserted.
- No internal storage beyond the single output word and the pointer. No data loss or duplication under any handshake pattern.

Test Plan:
- Reset: hold rst_n=0 with all in_valid=1 -> out_valid=0, out_data=0, in_ready=0 while in reset. Release in round-robin mode -> first transfer from channel 0, out_chan=0 one cycle later.
- Fixed mode, sel=2, in_data ch2=16'hBEEF, all in_valid=1, out_ready=1 -> only in_ready[2]=1. Next cycle out_data=16'hBEEF, out_chan=2.
- Round-robin, CHANNELS=4, all valid, out_ready=1 for 8 cycles -> out_chan sequence 0,1,2,3,0,1,2,3 with out_valid continuously 1.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 holding 16'h1234 from ch1 -> out_data/out_chan stable, all in_ready=0. Raise out_ready -> ch2 data appears next cycle with no word lost.
- Sparse requests: in_valid=4'b1001 with last=0 -> grant ch3, then ch0, then ch3. Drop in_valid[3] -> ch0 is served back-to-back.
- Async reset asserted mid-stall with out_valid=1 -> out_valid falls immediately, not at a clock edge. After release the pointer restarts at channel 0.
